// File: rtl/local_bus_pkg.sv
// Shared definitions for the local bus register file: FSM encoding,
// the register-space code and the address-phase field positions.
package local_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ALE0,
        ST_DECODE,
        ST_WAIT_CS,
        ST_ACK,
        ST_WAIT_RELEASE
    } state_t;

    localparam logic [1:0] REG_SPACE = 2'b00;

    localparam int ID_MSB    = 31;
    localparam int ID_LSB    = 28;
    localparam int SPACE_MSB = 27;
    localparam int SPACE_LSB = 26;
    localparam int IDX_MSB   = 7;
    localparam int IDX_LSB   = 0;
    localparam int IDX_W     = IDX_MSB - IDX_LSB + 1;

endpackage

// File: rtl/local_bus_ctrl_fsm.sv
// Local bus protocol engine: address latch, command decode, chip-select
// timeout and acknowledge handshake. Emits one-cycle wr_en/rd_en strobes.
module local_bus_ctrl_fsm
    import local_bus_pkg::*;
#(
    parameter logic [3:0] BLOCK_ID = 4'h1,
    parameter int         TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             rd_wr,
    input  logic             ale,
    input  logic [31:0]      addr_word,
    output logic             wr_en,
    output logic             rd_en,
    output logic [IDX_W-1:0] index,
    output logic             tmo_err,
    output logic             ack_n
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t           state_reg, state_next;
    logic [1:0]       space_reg, space_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic             rd_reg, rd_next;
    logic [TW-1:0]    tmo_reg, tmo_next;
    logic             ack_n_reg, ack_n_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            space_reg <= '0;
            index_reg <= '0;
            rd_reg    <= 1'b0;
            tmo_reg   <= '0;
            ack_n_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            space_reg <= space_next;
            index_reg <= index_next;
            rd_reg    <= rd_next;
            tmo_reg   <= tmo_next;
            ack_n_reg <= ack_n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        space_next = space_reg;
        index_next = index_reg;
        rd_next    = rd_reg;
        tmo_next   = tmo_reg;
        ack_n_next = ack_n_reg;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        tmo_err    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ale) state_next = ST_WAIT_ALE0;
            end
            ST_WAIT_ALE0: begin
                if (!ale) begin
                    if (addr_word[ID_MSB:ID_LSB] == BLOCK_ID) begin
                        space_next = addr_word[SPACE_MSB:SPACE_LSB];
                        index_next = addr_word[IDX_MSB:IDX_LSB];
                        state_next = ST_DECODE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DECODE: begin
                if (space_reg != REG_SPACE) begin
                    state_next = ST_IDLE;
                end else begin
                    rd_next    = rd_wr;
                    tmo_next   = '0;
                    state_next = ST_WAIT_CS;
                end
            end
            ST_WAIT_CS: begin
                // The access edge is the first one that samples cs_n low.
                if (!cs_n) begin
                    wr_en      = !rd_reg;
                    rd_en      = rd_reg;
                    state_next = ST_ACK;
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    tmo_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            ST_ACK: begin
                ack_n_next = 1'b0;
                space_next = '0;
                index_next = '0;
                state_next = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (cs_n) begin
                    ack_n_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign index = index_reg;
    assign ack_n = ack_n_reg;

endmodule

// File: rtl/local_bus_regfile.sv
// Local bus register file: NUM_RW control registers, NUM_RO status words,
// registered read data and a saturating error counter.
module local_bus_regfile
    import local_bus_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                NUM_RW   = 12,
    parameter int                NUM_RO   = 4,
    parameter logic [3:0]        BLOCK_ID = 4'h1,
    parameter logic [DATA_W-1:0] RST_VAL  = 32'd20110704,
    parameter int                TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs_n,
    input  logic                     rd_wr,
    input  logic                     ale,
    input  logic [DATA_W-1:0]        data,
    output logic [DATA_W-1:0]        data_out,
    output logic                     ack_n,
    output logic [NUM_RW*DATA_W-1:0] ctrl_q,
    output logic [NUM_RW-1:0]        wr_pulse,
    input  logic [NUM_RO*DATA_W-1:0] stat_in,
    output logic [15:0]              err_cnt
);

    localparam logic [IDX_W:0] WR_LIMIT = (IDX_W + 1)'(NUM_RW);
    localparam logic [IDX_W:0] RD_LIMIT = (IDX_W + 1)'(NUM_RW + NUM_RO);

    logic             wr_en, rd_en, tmo_err;
    logic [IDX_W-1:0] index;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] data_out_reg;
    logic [15:0]       err_cnt_reg;
    logic              unmapped_hit;

    local_bus_ctrl_fsm #(
        .BLOCK_ID (BLOCK_ID),
        .TIMEOUT  (TIMEOUT)
    ) u_ctrl_fsm (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .rd_wr     (rd_wr),
        .ale       (ale),
        .addr_word (data[31:0]),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .index     (index),
        .tmo_err   (tmo_err),
        .ack_n     (ack_n)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RW; gi++) begin : g_ctrl
            logic [DATA_W-1:0] q_reg;
            logic              pulse_reg;
            logic              hit;
            assign hit = wr_en && (index == IDX_W'(gi));
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_reg     <= RST_VAL;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    if (hit) q_reg <= data;
                end
            end
            assign ctrl_q[gi*DATA_W +: DATA_W] = q_reg;
            assign wr_pulse[gi]                = pulse_reg;
        end
    endgenerate

    // Unmapped indices fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (index == IDX_W'(i)) rd_word = ctrl_q[i*DATA_W +: DATA_W];
        for (int j = 0; j < NUM_RO; j++)
            if (index == IDX_W'(NUM_RW + j)) rd_word = stat_in[j*DATA_W +: DATA_W];
    end

    // Status words are read-only, so a write to them counts as unmapped.
    assign unmapped_hit = (wr_en && ({1'b0, index} >= WR_LIMIT)) ||
                          (rd_en && ({1'b0, index} >= RD_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            if (rd_en) data_out_reg <= rd_word;
            if ((unmapped_hit || tmo_err) && (err_cnt_reg != 16'hFFFF))
                err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign data_out = data_out_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: doc/local_bus_regfile.md
LOCAL_BUS_REGFILE -- requirements
Module: local_bus_regfile

Interface
REQ-001 SHALL have parameter DATA_W, 32, bus and register width (≥32; address phase uses data[31:26]).
REQ-002 SHALL have parameter NUM_RW, 12, number of read/write control registers (1..128).
REQ-003 SHALL have parameter NUM_RO, 4, number of read-only status registers (1..128; NUM_RW+NUM_RO ≤ 256).
REQ-004 SHALL have parameter BLOCK_ID, 4'h1, data[31:28] value that selects this block.
REQ-005 SHALL have parameter RST_VAL, 32'd20110704, reset value of every control register.
REQ-006 SHALL have parameter TIMEOUT, 255, maximum cycles in WAIT_CS before the command is abandoned.
REQ-007 SHALL have ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-low.
- cs_n  input  1  chip select, active-low.
- rd_wr  input  1  1=read, 0=write.
- ale  input  1  address latch enable.
- data  input  DATA_W  address phase / write data.
- data_out  output  DATA_W  read data.
- ack_n  output  1  acknowledge, active-low.
- ctrl_q  output  NUM_RW*DATA_W  control registers, reg i at [i*DATA_W +: DATA_W].
- wr_pulse  output  NUM_RW  one-cycle write strobe per control register.
- stat_in  input  NUM_RO*DATA_W  status words, reg j readable at index NUM_RW+j.
- err_cnt  output  16  saturating count of unmapped accesses plus timeouts.

Function
REQ-008 SHALL implement FSM IDLE, WAIT_ALE0, DECODE, WAIT_CS, ACK, WAIT_RELEASE.
REQ-009 IDLE: ale=1 -> WAIT_ALE0.
REQ-010 WAIT_ALE0: on ale=0, if data[31:28]==BLOCK_ID, latch addr=data[27:0] and go to DECODE; otherwise go to IDLE.
REQ-011 DECODE: if addr[27:26]!=2'b00 go to IDLE with no ack and no error; otherwise latch rd_wr, clear the timeout counter, and go to WAIT_CS.
REQ-012 WAIT_CS: on the first edge sampling cs_n=0, perform the access (index=addr[7:0]; addr[25:8] ignored), then go to ACK.
REQ-013 Write, index<NUM_RW: ctrl_q[index]<=data and wr_pulse[index]=1 for exactly that one following cycle; all other registers unchanged.
REQ-014 Read: index<NUM_RW gives ctrl_q[index]; NUM_RW≤index<NUM_RW+NUM_RO gives stat_in[index-NUM_RW], sampled on the access edge; the value is registered into data_out.
REQ-015 Unmapped index: write discarded; read sets data_out=0; err_cnt+1; ack still given.
REQ-016 WAIT_CS timeout: cs_n high for TIMEOUT consecutive cycles -> IDLE, no ack, err_cnt+1.
REQ-017 ACK: ack_n<=0, addr<=0, then go to WAIT_RELEASE.
REQ-018 WAIT_RELEASE: on cs_n=1, ack_n<=1 and go to IDLE; otherwise hold.
REQ-019 Latency: cs_n low sampled at edge N -> data_out/ctrl_q valid after edge N, ack_n low after edge N+1; ack_n high after the first edge that samples cs_n=1.
REQ-020 ale SHALL be ignored in every state other than IDLE and WAIT_ALE0.
REQ-021 data_out SHALL hold its last value between reads; writes SHALL NOT alter it.
REQ-022 err_cnt SHALL saturate at 16'hFFFF; if an unmapped access and a timeout coincide, only one increment SHALL occur.

Reset
REQ-023 On reset low (asynchronous): ack_n=1, data_out=0, ctrl_q all RST_VAL, wr_pulse=0, err_cnt=0, addr=0, timeout counter=0, state=IDLE.
REQ-024 Reset mid-transaction SHALL abort the transaction with no ack and no register update.

Structure
REQ-025 Shared package local_bus_pkg SHALL hold the FSM state encoding, the register-space code 2'b00, and the field positions (id [31:28], space [27:26], index [7:0]).
REQ-026 Protocol FSM, address latch and timeout counter SHALL live in sub-module local_bus_ctrl_fsm, which emits wr_en/rd_en/index; the register array, read mux and err_cnt SHALL stay in the top level.

Verification
REQ-027 Reset, then read index 0x00 -> data_out=32'h0132DD70; ack_n low one cycle after cs_n is sampled low; ack_n high after cs_n rises.
REQ-028 Address 0x1000_0005, write 0xA5A5_5A5A -> ctrl_q reg5=0xA5A5_5A5A; wr_pulse=12'h020 for one cycle; all other registers remain 0x0132DD70.
REQ-029 stat_in[0]=0xCAFE_F00D, read index 0x0C -> data_out=0xCAFE_F00D; then write index 0x0C -> no change, err_cnt=1.
REQ-030 Read index 0xFF -> data_out=0, ack given, err_cnt increments; address 0x2000_0001 or 0x1400_0001 -> no ack, FSM returns to IDLE, err_cnt unchanged.
REQ-031 Valid command, cs_n held high 300 cycles -> IDLE after 255 cycles, ack_n stays 1, err_cnt+1; a later command succeeds.
REQ-032 Reset asserted in WAIT_RELEASE -> ack_n=1 immediately; ctrl_q=RST_VAL; next transaction completes normally.
